// File: rtl/epc_rx_pkg.sv
// Shared constants and state encoding for the Gen2 PC+EPC+CRC-16 receive path.
package epc_rx_pkg;
   localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
   localparam logic [15:0] CRC16_POLY    = 16'h1021;
   localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

   localparam int PC_LEN_HI = 15;
   localparam int PC_LEN_LO = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PC,
      ST_EPC,
      ST_CRC,
      ST_FIN
   } state_t;
endpackage

// File: rtl/crc16_ser.sv
// Bit-serial CRC-16 (x^16+x^12+x^5+1), MSB first; init presets, en advances one bit.
module crc16_ser
   import epc_rx_pkg::*;
(
   input  logic        epcclk,
   input  logic        reset,
   input  logic        init,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);
   logic [15:0] crc_next;

   assign crc_next = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);

   always_ff @(posedge epcclk) begin
      if (reset || init) begin
         crc <= CRC16_PRESET;
      end else if (en) begin
         crc <= crc_next;
      end
   end
endmodule

// File: rtl/epc_rx.sv
// Serial receiver for a Gen2 PC+EPC+CRC-16 reply; captures PC, length-driven EPC, checks CRC.
module epc_rx
   import epc_rx_pkg::*;
#(
   parameter int MAXWORDS = 6
)(
   input  logic                    epcclk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    bitin,
   input  logic                    bitvalid,
   output logic                    busy,
   output logic                    done,
   output logic                    crcok,
   output logic                    lenerr,
   output logic [15:0]             pc,
   output logic [MAXWORDS*16-1:0]  epc,
   output logic [4:0]              epcwords
);
   localparam int          EW     = MAXWORDS * 16;
   localparam logic [5:0]  MAXLEN = 6'(MAXWORDS);

   state_t      state, state_nxt;
   logic [6:0]  cnt, cnt_nxt;
   logic        take, pc_last, epc_last, crc_last, crc_chk;
   logic [15:0] pc_shift, crc;
   logic [4:0]  pc_len;
   logic [8:0]  epc_bits, cnt_inc;

   assign take     = bitvalid && !start &&
                     (state == ST_PC || state == ST_EPC || state == ST_CRC);
   assign pc_shift = {pc[14:0], bitin};
   assign pc_len   = pc_shift[PC_LEN_HI:PC_LEN_LO];
   // EPC length compared at 9 bits so epcwords*16 never wraps
   assign epc_bits = {epcwords, 4'b0000};
   assign cnt_inc  = {2'b00, cnt} + 9'd1;
   assign pc_last  = take && (state == ST_PC)  && (cnt == 7'd15);
   assign epc_last = take && (state == ST_EPC) && (cnt_inc == epc_bits);
   assign crc_last = take && (state == ST_CRC) && (cnt == 7'd15);

   assign busy  = (state == ST_PC) || (state == ST_EPC) || (state == ST_CRC);
   assign done  = (state == ST_FIN);
   // crc holds after the last CRC bit, so the residue is checked from the register
   assign crcok = crc_chk && (crc == CRC16_RESIDUE);

   crc16_ser u_crc (
      .epcclk (epcclk),
      .reset  (reset),
      .init   (start),
      .en     (take),
      .din    (bitin),
      .crc    (crc)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = take ? cnt + 7'd1 : cnt;
      case (state)
         ST_PC: begin
            if (pc_last) begin
               cnt_nxt = 7'd0;
               if ({1'b0, pc_len} > MAXLEN) state_nxt = ST_FIN;
               else if (pc_len == 5'd0)     state_nxt = ST_CRC;
               else                         state_nxt = ST_EPC;
            end
         end
         ST_EPC: begin
            if (epc_last) begin
               cnt_nxt   = 7'd0;
               state_nxt = ST_CRC;
            end
         end
         ST_CRC: begin
            if (crc_last) begin
               cnt_nxt   = 7'd0;
               state_nxt = ST_FIN;
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = state;
      endcase
      if (start) begin
         state_nxt = ST_PC;
         cnt_nxt   = 7'd0;
      end
   end

   always_ff @(posedge epcclk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= 7'd0;
         pc       <= 16'd0;
         epc      <= '0;
         epcwords <= 5'd0;
         lenerr   <= 1'b0;
         crc_chk  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (start) begin
            pc       <= 16'd0;
            epc      <= '0;
            epcwords <= 5'd0;
            lenerr   <= 1'b0;
            crc_chk  <= 1'b0;
         end else if (take) begin
            if (state == ST_PC) begin
               pc <= pc_shift;
               if (pc_last) begin
                  epcwords <= pc_len;
                  lenerr   <= ({1'b0, pc_len} > MAXLEN);
               end
            end
            if (state == ST_EPC) epc <= {epc[EW-2:0], bitin};
            if (crc_last)        crc_chk <= 1'b1;
         end
      end
   end
endmodule

// File: doc/epc_rx.md
# epc_rx

Serial receiver for a Gen2 PC+EPC+CRC-16 backscatter reply: the receiving end of the tag's EPC bit stream. It accepts one bit per qualified clock, MSB first, and captures the 16-bit PC. It uses the PC length field to capture the EPC words, then checks the trailing CRC-16. It sits behind the bit-level demodulator in the reader-side/loopback test path. It hands a parsed PC, EPC and status to the command layer.

## Interface
Parameters:
- MAXWORDS, 6, maximum EPC length in 16-bit words accepted; EPC register width is MAXWORDS*16.

Ports:
- epcclk  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: clear outputs and begin a new frame.
- bitin  input  1  serial data bit.
- bitvalid  input  1  bitin is qualified this cycle.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the frame ends, either completed or aborted.
- crcok  output  1  CRC residue correct; valid from done until the next start.
- lenerr  output  1  PC length field exceeded MAXWORDS; valid from done until the next start.
- pc  output  16  received PC word.
- epc  output  MAXWORDS*16  received EPC, right-justified; unused upper bits are 0.
- epcwords  output  5  PC[15:11] as received.

## Operation
- States: IDLE, PC, EPC, CRC, FIN.
- IDLE: waits for start.
- start in any state, including mid-frame:
  - clears pc, epc, epcwords, crcok, lenerr and the bit counter;
  - presets the CRC register to 16'hFFFF;
  - enters PC.
- start and bitvalid in the same cycle: start wins and the bit is discarded.
- Every qualified bit in PC, EPC or CRC updates the CRC-16 register:
  - polynomial x^16+x^12+x^5+1 (0x1021);
  - feedback = crc[15] ^ bitin;
  - crc <= {crc[14:0],1'b0} ^ (feedback ? 16'h1021 : 0).
- PC state:
  - shifts bitin into pc LSB: pc <= {pc[14:0], bitin};
  - after the 16th bit, epcwords takes the value of the new pc[15:11].
  - If the length field is greater than MAXWORDS: lenerr <= 1, go to FIN.
  - If the length field is 0: go to CRC.
  - Otherwise: go to EPC.
- EPC state:
  - shifts bitin into the epc LSB;
  - leaves after epcwords*16 bits and goes to CRC;
  - the first EPC bit ends up at bit epcwords*16-1.
- CRC state:
  - consumes 16 bits through the CRC register only; pc and epc are untouched;
  - after the 16th bit, crcok <= (crc_next == 16'h1D0F) and the block goes to FIN.
- FIN: asserts done for one cycle, then returns to IDLE. Outputs hold their values.
- bitvalid in IDLE or FIN is ignored.
- Bit counter: 7 bits, counts qualified bits within the current field and resets at each field change.
- Width rule: epcwords*16 is compared using the full counter width, with no truncation.

## Timing
- Reset values: busy 0, done 0, crcok 0, lenerr 0, pc 0, epc 0, epcwords 0. State is IDLE.
- busy rises the cycle after start and falls in the cycle done is asserted.
- Field registers update on the same edge that samples the qualifying bitvalid.
- done is asserted in the cycle after the edge that accepts the last CRC bit, or the 16th PC bit if lenerr is set.
- No minimum spacing between bits: bitvalid may be high on every cycle.
- Gaps of any length between bits are allowed; there is no timeout.
- Full frame, L=6: 128 qualified bits. done occurs 1 cycle after the 128th accepted bit.
- Reset mid-frame: all outputs return to reset values on the next edge, with no done pulse.

## Structure
- Shared package/include:
  - CRC16_PRESET = 16'hFFFF;
  - CRC16_POLY = 16'h1021;
  - CRC16_RESIDUE = 16'h1D0F;
  - state encodings;
  - PC field positions (length field [15:11]).
- Sub-module crc16_ser:
  - serial CRC-16 with init/enable inputs and a 16-bit state output;
  - reusable by the tag-side transmit CRC generator.

## Test plan
- PC=16'h3000, EPC=96'haabbccddeeff012345678910, correct CRC-16 from the bench model, bitvalid every cycle. Required: pc=3000, epcwords=6, epc=aabb…8910, crcok=1, lenerr=0, done 1 cycle after bit 128.
- Same frame with CRC bit 3 flipped. Required: identical pc/epc, crcok=0, done at the same cycle.
- PC=16'h1000 (2 words), EPC=32'hDEADBEEF, valid CRC, random bitvalid gaps of 0–5 cycles. Required: epc=…0000DEADBEEF, upper bits 0, crcok=1.
- PC=16'h3800 (7 words > MAXWORDS). Required: lenerr=1, done 1 cycle after the 16th bit, later bits ignored, crcok=0.
- PC=16'h0000 plus valid CRC (32 bits total). Required: epc=0, crcok=1, done after bit 32.
- Two abort cases:
  - start asserted after 50 bits of a frame, then a full valid frame: only one done, for the second frame, with correct values;
  - reset after 70 bits: all outputs 0 on the next cycle and no done.
